// File: rtl/note_event_decoder_if.sv
// rtl/note_event_decoder_if.sv - byte stream in, held-key bitmap out, for note_event_decoder
interface note_event_decoder_if #(
    parameter int NUM_KEYS = 32
);
    logic [7:0]          i_byte;
    logic                i_valid;
    logic                o_ready;
    logic [NUM_KEYS-1:0] o_keys;
    logic                o_key_event;
    logic [5:0]          o_active;

    modport master (
        output i_byte, i_valid,
        input  o_ready, o_keys, o_key_event, o_active
    );

    modport slave (
        input  i_byte, i_valid,
        output o_ready, o_keys, o_key_event, o_active
    );
endinterface

// File: rtl/note_event_decoder.sv
// rtl/note_event_decoder.sv - MIDI-style note message parser maintaining a held-key bitmap
module note_event_decoder #(
    parameter int BASE_NOTE   = 60,
    parameter int NUM_KEYS    = 32,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    note_event_decoder_if.slave   bus
);
    localparam int IDXW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int TCW  = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, DATA1, DATA2, APPLY} state_t;

    state_t              state_q, state_d;
    logic [7:0]          status_q, status_d;
    logic                rs_valid_q, rs_valid_d;
    logic [7:0]          d1_q, d1_d;
    logic [7:0]          d2_q, d2_d;
    logic [NUM_KEYS-1:0] keys_q, keys_d;
    logic [5:0]          active_q, active_d;
    logic                event_q, event_d;
    logic [TCW-1:0]      tcnt_q, tcnt_d;

    logic       accept;
    logic       is_data, is_rt, is_sys, is_chan;
    logic       one_byte_msg;
    logic       note_in_range;
    logic [7:0] note_off;

    assign bus.o_ready     = (state_q != APPLY);
    assign bus.o_keys      = keys_q;
    assign bus.o_key_event = event_q;
    assign bus.o_active    = active_q;

    assign accept  = bus.i_valid & bus.o_ready;
    assign is_data = ~bus.i_byte[7];
    assign is_rt   = (bus.i_byte >= 8'hF8);
    assign is_sys  = (bus.i_byte[7:4] == 4'hF) & ~is_rt;
    assign is_chan = bus.i_byte[7] & (bus.i_byte[7:4] != 4'hF);

    // Program change and channel pressure carry a single data byte.
    assign one_byte_msg  = (status_q[7:4] == 4'hC) | (status_q[7:4] == 4'hD);
    assign note_off      = d1_q - 8'(BASE_NOTE);
    assign note_in_range = ({1'b0, d1_q} >= 9'(BASE_NOTE)) &&
                           ({1'b0, d1_q} <  9'(BASE_NOTE + NUM_KEYS));

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        rs_valid_d = rs_valid_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        keys_d     = keys_q;
        event_d    = 1'b0;
        tcnt_d     = '0;
        active_d   = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_chan) begin
                        status_d   = bus.i_byte;
                        rs_valid_d = 1'b1;
                        state_d    = DATA1;
                    end else if (is_sys) begin
                        rs_valid_d = 1'b0;
                    end else if (is_data && rs_valid_q && !one_byte_msg) begin
                        d1_d    = bus.i_byte;
                        state_d = DATA2;
                    end
                end
            end
            DATA1, DATA2: begin
                tcnt_d = tcnt_q;
                if (accept && !is_rt) begin
                    tcnt_d = '0;
                    if (is_chan) begin
                        status_d   = bus.i_byte;
                        rs_valid_d = 1'b1;
                        state_d    = DATA1;
                    end else if (is_sys) begin
                        rs_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else if (state_q == DATA1) begin
                        if (one_byte_msg) begin
                            state_d = IDLE;
                        end else begin
                            d1_d    = bus.i_byte;
                            state_d = DATA2;
                        end
                    end else begin
                        d2_d    = bus.i_byte;
                        state_d = APPLY;
                    end
                end else if (!accept) begin
                    // A stalled partial message is dropped; running status survives.
                    if (tcnt_q == TCW'(TIMEOUT_CYC - 1)) begin
                        tcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TCW'(1);
                    end
                end
            end
            APPLY: begin
                state_d = IDLE;
                if (note_in_range) begin
                    if (status_q[7:4] == 4'h9) begin
                        keys_d[note_off[IDXW-1:0]] = (d2_q != 8'h00);
                    end else if (status_q[7:4] == 4'h8) begin
                        keys_d[note_off[IDXW-1:0]] = 1'b0;
                    end
                end
                if ((status_q[7:4] == 4'hB) && ((d1_q == 8'h7B) || (d1_q == 8'h78))) begin
                    keys_d = '0;
                end
                event_d = (keys_d != keys_q);
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < NUM_KEYS; i++) begin
            active_d = active_d + 6'(keys_d[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            status_q   <= '0;
            rs_valid_q <= 1'b0;
            d1_q       <= '0;
            d2_q       <= '0;
            keys_q     <= '0;
            active_q   <= '0;
            event_q    <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            rs_valid_q <= rs_valid_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            keys_q     <= keys_d;
            active_q   <= active_d;
            event_q    <= event_d;
            tcnt_q     <= tcnt_d;
        end
    end
endmodule

// File: tb/tb_note_event_decoder.sv
// tb/tb_note_event_decoder.sv - table-driven bench with key-event scoreboard for note_event_decoder
module tb_note_event_decoder;
    localparam int NUM_KEYS    = 32;
    localparam int BASE_NOTE   = 60;
    localparam int TIMEOUT_CYC = 20;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    note_event_decoder_if #(.NUM_KEYS(NUM_KEYS)) bus ();

    note_event_decoder #(
        .BASE_NOTE  (BASE_NOTE),
        .NUM_KEYS   (NUM_KEYS),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [47:0] bytes;
        int          n;
        logic [31:0] exp;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_keys = '0;
    logic [31:0] mon_e;
    vec_t        vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_keys(input logic [31:0] nk);
        if (nk != model_keys) exp_q.push_back(nk);
        model_keys = nk;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        @(negedge i_clk);
        while (!bus.o_ready && guard < 10) begin
            guard++;
            @(negedge i_clk);
        end
        if (guard >= 10) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: o_ready=%0b expected 1", bus.o_ready);
        end
        bus.i_byte  = b;
        bus.i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic settle_check(input string name);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check({name, "_keys"}, bus.o_keys, model_keys);
        check({name, "_active"}, 32'(bus.o_active), 32'($countones(model_keys)));
    endtask

    // Every o_key_event pulse must match the oldest expected bitmap change.
    always @(negedge i_clk) begin
        if (i_rst_n && bus.o_key_event) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: keys=0x%0h expected no event", bus.o_keys);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_keys", bus.o_keys, mon_e);
                check("event_active", 32'(bus.o_active), 32'($countones(mon_e)));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{48'h3E40_0000_0000, 2, 32'h0000_0005};
        vecs[1]  = '{48'h3C00_0000_0000, 2, 32'h0000_0004};
        vecs[2]  = '{48'h905C_4000_0000, 3, 32'h0000_0004};
        vecs[3]  = '{48'h903E_4000_0000, 3, 32'h0000_0004};
        vecs[4]  = '{48'h803E_0000_0000, 3, 32'h0000_0000};
        vecs[5]  = '{48'h90F8_3DFE_7F00, 5, 32'h0000_0002};
        vecs[6]  = '{48'h903D_F040_0000, 4, 32'h0000_0002};
        vecs[7]  = '{48'h3D40_0000_0000, 2, 32'h0000_0002};
        vecs[8]  = '{48'h903E_0100_0000, 3, 32'h0000_0006};
        vecs[9]  = '{48'hA03E_0000_0000, 3, 32'h0000_0006};
        vecs[10] = '{48'hC005_3E00_0000, 3, 32'h0000_0006};
        vecs[11] = '{48'h903E_903F_4000, 5, 32'h0000_000E};
        vecs[12] = '{48'hB007_0000_0000, 3, 32'h0000_000E};
        vecs[13] = '{48'hB07B_0000_0000, 3, 32'h0000_0000};
        vecs[14] = '{48'h903B_4000_0000, 3, 32'h0000_0000};
        vecs[15] = '{48'h905B_4000_0000, 3, 32'h8000_0000};
        vecs[16] = '{48'hB178_0000_0000, 3, 32'h0000_0000};
        vecs[17] = '{48'h903C_0000_0000, 3, 32'h0000_0000};

        bus.i_byte  = 8'h00;
        bus.i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_keys", bus.o_keys, 32'h0);
        check("reset_active", 32'(bus.o_active), 32'h0);
        check("reset_event", 32'(bus.o_key_event), 32'h0);
        check("reset_ready", 32'(bus.o_ready), 32'h1);
        i_rst_n = 1'b1;

        // Note-on with exact update timing.
        send_byte(8'h90);
        send_byte(8'h3C);
        expect_keys(32'h1);
        send_byte(8'h64);
        check("t1_ready_low", 32'(bus.o_ready), 32'h0);
        check("t1_keys_before", bus.o_keys, 32'h0);
        @(posedge i_clk);
        #1;
        check("t1_keys", bus.o_keys, 32'h1);
        check("t1_active", 32'(bus.o_active), 32'h1);
        check("t1_event", 32'(bus.o_key_event), 32'h1);
        check("t1_ready_back", 32'(bus.o_ready), 32'h1);
        @(posedge i_clk);
        #1;
        check("t1_event_off", 32'(bus.o_key_event), 32'h0);

        for (int v = 0; v < 18; v++) begin
            logic [47:0] bb;
            bb = vecs[v].bytes;
            for (int k = 0; k < vecs[v].n; k++) begin
                if (k == vecs[v].n - 1) expect_keys(vecs[v].exp);
                send_byte(bb[47 - 8*k -: 8]);
            end
            settle_check($sformatf("vec%0d", v));
        end

        // Fill every key through running status, then all-notes-off.
        send_byte(8'h90);
        for (int i = 0; i < NUM_KEYS; i++) begin
            send_byte(8'(BASE_NOTE + i));
            expect_keys(model_keys | (32'h1 << i));
            send_byte(8'h40);
        end
        settle_check("all_on");
        send_byte(8'hB5);
        send_byte(8'h7B);
        expect_keys(32'h0);
        send_byte(8'h00);
        settle_check("all_off");

        // One cycle short of the timeout the message still completes.
        send_byte(8'h90);
        send_byte(8'h3F);
        repeat (TIMEOUT_CYC - 1) @(posedge i_clk);
        expect_keys(32'h8);
        send_byte(8'h40);
        settle_check("pre_timeout");
        send_byte(8'h80);
        send_byte(8'h3F);
        expect_keys(32'h0);
        send_byte(8'h00);
        settle_check("clear3");

        // Full timeout drops the partial but keeps running status.
        send_byte(8'h90);
        send_byte(8'h3F);
        repeat (TIMEOUT_CYC) @(posedge i_clk);
        send_byte(8'h41);
        expect_keys(32'h20);
        send_byte(8'h40);
        settle_check("timeout");

        send_byte(8'h90);
        send_byte(8'h3C);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        check("midrst_keys", bus.o_keys, 32'h0);
        check("midrst_active", 32'(bus.o_active), 32'h0);
        check("midrst_event", 32'(bus.o_key_event), 32'h0);
        check("midrst_ready", 32'(bus.o_ready), 32'h1);
        model_keys = '0;
        exp_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send_byte(8'h3C);
        send_byte(8'h40);
        settle_check("post_reset");

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
